// File: rtl/french_move_multi.sv
// french_move_multi: moves NUM_OBJ enemy sprites in a rectangular play field.
// Each sprite moves one step of SPEED pixels per accepted game tick.
// A sprite picks a new direction from the shared random nibble every HOLD_TICKS ticks.
// A sprite never leaves the field limits.
//
// Ports:
//   CLK           system clock
//   RESET         asynchronous active-high reset
//   timer_done    one-cycle game tick strobe
//   enable        1 = walking active, 0 = ticks dropped and state frozen
//   random        shared random nibble, bits [3:2] used on a direction pick
//   respawn       per-sprite return-to-start pulse; it wins over a tick on the same cycle
//   ObjectStartX  packed X, sprite i at [i*COORD_W +: COORD_W]
//   ObjectStartY  packed Y, same packing
//   direction     2 bits per sprite (0 UP, 1 DOWN, 2 RIGHT, 3 LEFT)
//   blocked       1 = the sprite's last tick move was refused by a limit
//
// Optional feature macro: BOUNCE_EN
//   When it is defined, a refused move reverses the direction.
//   The reversed step is taken on the same tick if that step is legal.

module french_move_multi #(
    parameter int unsigned NUM_OBJ     = 4,
    parameter int unsigned COORD_W     = 11,
    parameter int unsigned SPEED       = 3,
    parameter int unsigned HOLD_TICKS  = 4,
    parameter int unsigned SIZE        = 26,
    parameter int unsigned LIMIT_LEFT  = 45,
    parameter int unsigned LIMIT_RIGHT = 635,
    parameter int unsigned LIMIT_UP    = 85,
    parameter int unsigned LIMIT_DOWN  = 393,
    parameter int unsigned START_X     = 200,
    parameter int unsigned START_Y     = 250,
    parameter int unsigned START_DX    = 40
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         timer_done,
    input  logic                         enable,
    input  logic [3:0]                   random,
    input  logic [NUM_OBJ-1:0]           respawn,
    output logic [NUM_OBJ*COORD_W-1:0]   ObjectStartX,
    output logic [NUM_OBJ*COORD_W-1:0]   ObjectStartY,
    output logic [2*NUM_OBJ-1:0]         direction,
    output logic [NUM_OBJ-1:0]           blocked
);

    localparam int unsigned CntW  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int unsigned WideW = COORD_W + 1;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirDown  = 2'd1,
        DirRight = 2'd2,
        DirLeft  = 2'd3
    } dir_t;

    logic [COORD_W-1:0] x_q   [NUM_OBJ];
    logic [COORD_W-1:0] x_d   [NUM_OBJ];
    logic [COORD_W-1:0] y_q   [NUM_OBJ];
    logic [COORD_W-1:0] y_d   [NUM_OBJ];
    dir_t               dir_q [NUM_OBJ];
    dir_t               dir_d [NUM_OBJ];
    logic [CntW-1:0]    cnt_q [NUM_OBJ];
    logic [CntW-1:0]    cnt_d [NUM_OBJ];
    logic [NUM_OBJ-1:0] blk_q;
    logic [NUM_OBJ-1:0] blk_d;

    logic tick;
    logic unused_random;

    assign tick          = timer_done & enable;
    assign unused_random = ^random[1:0];

    // The limit tests are done one bit wider than the coordinates, so the sums cannot wrap.
    // The UP and LEFT tests compare against limit+SPEED instead of subtracting.
    function automatic logic move_legal(dir_t d, logic [COORD_W-1:0] x, logic [COORD_W-1:0] y);
        logic [WideW-1:0] xw;
        logic [WideW-1:0] yw;
        logic             ok;
        xw = {1'b0, x};
        yw = {1'b0, y};
        unique case (d)
            DirUp:    ok = yw >= WideW'(LIMIT_UP + SPEED);
            DirDown:  ok = (yw + WideW'(SIZE + SPEED)) <= WideW'(LIMIT_DOWN);
            DirRight: ok = (xw + WideW'(SIZE + SPEED)) <= WideW'(LIMIT_RIGHT);
            DirLeft:  ok = xw >= WideW'(LIMIT_LEFT + SPEED);
        endcase
        return ok;
    endfunction

    function automatic logic [COORD_W-1:0] step_x(dir_t d, logic [COORD_W-1:0] x);
        logic [COORD_W-1:0] nx;
        nx = x;
        if (d == DirRight) nx = x + COORD_W'(SPEED);
        if (d == DirLeft)  nx = x - COORD_W'(SPEED);
        return nx;
    endfunction

    function automatic logic [COORD_W-1:0] step_y(dir_t d, logic [COORD_W-1:0] y);
        logic [COORD_W-1:0] ny;
        ny = y;
        if (d == DirDown) ny = y + COORD_W'(SPEED);
        if (d == DirUp)   ny = y - COORD_W'(SPEED);
        return ny;
    endfunction

    always_comb begin
        dir_t pick;
        dir_t rev;
        pick  = DirRight;
        rev   = DirLeft;
        blk_d = blk_q;
        for (int i = 0; i < NUM_OBJ; i++) begin
            x_d[i]   = x_q[i];
            y_d[i]   = y_q[i];
            dir_d[i] = dir_q[i];
            cnt_d[i] = cnt_q[i];
            if (respawn[i]) begin
                x_d[i]   = COORD_W'(START_X + i * START_DX);
                y_d[i]   = COORD_W'(START_Y);
                dir_d[i] = DirRight;
                cnt_d[i] = '0;
                blk_d[i] = 1'b0;
            end else if (tick) begin
                if (cnt_q[i] == '0) begin
                    // The index offset keeps sprites from marching in lockstep.
                    pick     = dir_t'(random[3:2] + 2'(i));
                    cnt_d[i] = CntW'(HOLD_TICKS - 1);
                end else begin
                    pick     = dir_q[i];
                    cnt_d[i] = cnt_q[i] - CntW'(1);
                end
                if (move_legal(pick, x_q[i], y_q[i])) begin
                    x_d[i]   = step_x(pick, x_q[i]);
                    y_d[i]   = step_y(pick, y_q[i]);
                    dir_d[i] = pick;
                    blk_d[i] = 1'b0;
                end else begin
`ifdef BOUNCE_EN
                    // Flipping bit 0 swaps UP<->DOWN and RIGHT<->LEFT.
                    rev      = dir_t'({pick[1], ~pick[0]});
                    dir_d[i] = rev;
                    if (move_legal(rev, x_q[i], y_q[i])) begin
                        x_d[i] = step_x(rev, x_q[i]);
                        y_d[i] = step_y(rev, y_q[i]);
                    end
`else
                    dir_d[i] = pick;
`endif
                    blk_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                x_q[i]   <= COORD_W'(START_X + i * START_DX);
                y_q[i]   <= COORD_W'(START_Y);
                dir_q[i] <= DirRight;
                cnt_q[i] <= '0;
            end
            blk_q <= '0;
        end else begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                x_q[i]   <= x_d[i];
                y_q[i]   <= y_d[i];
                dir_q[i] <= dir_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            blk_q <= blk_d;
        end
    end

    always_comb begin
        ObjectStartX = '0;
        ObjectStartY = '0;
        direction    = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            ObjectStartX[i*COORD_W +: COORD_W] = x_q[i];
            ObjectStartY[i*COORD_W +: COORD_W] = y_q[i];
            direction[2*i +: 2]                = dir_q[i];
        end
    end

    assign blocked = blk_q;

endmodule

// File: tb/tb_french_move_multi.sv
// Directed self-checking bench for french_move_multi with the default parameters.
// All expected positions and directions below are worked out by hand from the walk rules.

module tb_french_move_multi;

    logic        CLK;
    logic        RESET;
    logic        timer_done;
    logic        enable;
    logic [3:0]  random;
    logic [3:0]  respawn;
    logic [43:0] ObjectStartX;
    logic [43:0] ObjectStartY;
    logic [7:0]  direction;
    logic [3:0]  blocked;

    int checks;
    int errors;

    french_move_multi dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .timer_done   (timer_done),
        .enable       (enable),
        .random       (random),
        .respawn      (respawn),
        .ObjectStartX (ObjectStartX),
        .ObjectStartY (ObjectStartY),
        .direction    (direction),
        .blocked      (blocked)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_pos(input int i, input int ex, input int ey);
        check_val($sformatf("x%0d", i), 64'(ObjectStartX[i*11 +: 11]), 64'(ex));
        check_val($sformatf("y%0d", i), 64'(ObjectStartY[i*11 +: 11]), 64'(ey));
    endtask

    // Called at a falling edge; the strobe covers exactly one rising edge.
    task automatic tick();
        timer_done = 1'b1;
        @(negedge CLK);
        timer_done = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_pos(0, 200, 250);
        check_pos(1, 240, 250);
        check_pos(2, 280, 250);
        check_pos(3, 320, 250);
        check_val({tag, "_dir"}, 64'(direction), 64'(8'b10_10_10_10));
        check_val({tag, "_blk"}, 64'(blocked), 64'(4'b0000));
    endtask

    // Expected state after the first tick with random=1000 (sprites: RIGHT, LEFT, UP, DOWN).
    task automatic check_first_tick(input string tag);
        check_pos(0, 203, 250);
        check_pos(1, 237, 250);
        check_pos(2, 280, 247);
        check_pos(3, 320, 253);
        check_val({tag, "_dir"}, 64'(direction), 64'(8'b01_00_11_10));
        check_val({tag, "_blk"}, 64'(blocked), 64'(4'b0000));
    endtask

    // Expected state after tick 5: a new pick with random=0 gives UP, DOWN, RIGHT, LEFT.
    task automatic check_tick5(input string tag);
        check_pos(0, 212, 247);
        check_pos(1, 228, 253);
        check_pos(2, 283, 238);
        check_pos(3, 317, 262);
        check_val({tag, "_dir"}, 64'(direction), 64'(8'b11_10_01_00));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        RESET      = 1'b1;
        timer_done = 1'b0;
        enable     = 1'b1;
        random     = 4'b0000;
        respawn    = 4'b0000;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check_reset_state("reset");

        random = 4'b1000;
        tick();
        check_first_tick("tick1");

        // Ticks 2-4 keep the stored direction even though random changed.
        random = 4'b0000;
        repeat (3) tick();
        check_pos(0, 212, 250);
        check_pos(1, 228, 250);
        check_pos(2, 280, 238);
        check_pos(3, 320, 262);
        check_val("hold_dir", 64'(direction), 64'(8'b01_00_11_10));

        tick();
        check_tick5("tick5");

        // A dropped tick changes nothing.
        enable = 1'b0;
        tick();
        check_tick5("disabled");
        check_val("disabled_blk", 64'(blocked), 64'(4'b0000));
        enable = 1'b1;

        // A respawn of sprite 1 on a tick; the other sprites keep holding and move.
        respawn = 4'b0010;
        tick();
        respawn = 4'b0000;
        check_pos(0, 212, 244);
        check_pos(1, 240, 250);
        check_pos(2, 286, 238);
        check_pos(3, 314, 262);
        check_val("respawn_dir", 64'(direction), 64'(8'b11_10_10_00));

        // An asynchronous reset in the middle of a hold is seen before any clock edge.
        #2 RESET = 1'b1;
        #1 check_reset_state("async_reset");
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check_reset_state("post_reset");

        // The first tick after reset picks for every sprite.
        random = 4'b1000;
        tick();
        check_first_tick("repick");

        // Walk to the limits: 136 ticks in total from the start positions.
        repeat (135) tick();
        check_pos(0, 608, 250);
`ifndef BOUNCE_EN
        check_pos(1, 45, 250);
        check_pos(2, 280, 85);
        check_pos(3, 320, 367);
        check_val("edge_blk", 64'(blocked), 64'(4'b1110));
        check_val("edge_dir", 64'(direction), 64'(8'b01_00_11_10));
`else
        check_val("edge_blk0", 64'(blocked[0]), 64'(1'b0));
`endif

        // Sprite 0 is now 608+26+3=637 past the right limit, so its next step is refused.
        tick();
`ifndef BOUNCE_EN
        check_pos(0, 608, 250);
        check_pos(1, 45, 250);
        check_val("refuse_blk", 64'(blocked), 64'(4'b1111));
        check_val("refuse_dir", 64'(direction), 64'(8'b01_00_11_10));
`else
        check_pos(0, 605, 250);
        check_val("bounce_blk0", 64'(blocked[0]), 64'(1'b1));
        check_val("bounce_dir0", 64'(direction[1:0]), 64'(2'd3));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/french_move_multi.md
Name: french_move_multi

Overview:
- Parametrised successor of the single-sprite random walker for the VGA frog game.
- Moves NUM_OBJ enemy sprites independently inside a rectangular play field, one step per game tick.
- Each sprite picks a new direction from a shared 4-bit random source every HOLD_TICKS ticks and stops cleanly at the field limits.
- Feeds the per-object drawing and collision logic with registered top-left coordinates.

Parameters:
NUM_OBJ, 4, number of independent sprites (1..8)
COORD_W, 11, coordinate width in bits
SPEED, 3, pixels moved per tick
HOLD_TICKS, 4, ticks a chosen direction is kept (>=1)
SIZE, 26, sprite width/height in pixels
LIMIT_LEFT, 45, minimum legal X
LIMIT_RIGHT, 635, maximum legal X+SIZE
LIMIT_UP, 85, minimum legal Y
LIMIT_DOWN, 393, maximum legal Y+SIZE
START_X, 200, X of sprite 0 at reset/respawn
START_Y, 250, Y of every sprite at reset/respawn
START_DX, 40, X spacing: sprite i starts at START_X + i*START_DX

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
timer_done  in  1  one-cycle game tick strobe
enable  in  1  1 = walking active; 0 = ticks ignored, all state frozen
random  in  4  shared random nibble, sampled on tick
respawn  in  NUM_OBJ  per-sprite pulse: return sprite to start position
ObjectStartX  out  NUM_OBJ*COORD_W  packed X, sprite i at bits [i*COORD_W +: COORD_W]
ObjectStartY  out  NUM_OBJ*COORD_W  packed Y, same packing
direction  out  2*NUM_OBJ  current direction per sprite (0 UP, 1 DOWN, 2 RIGHT, 3 LEFT)
blocked  out  NUM_OBJ  1 = sprite's last tick move was refused by a limit

Behaviour:
- Reset (asynchronous, RESET=1): X_i = START_X + i*START_DX; Y_i = START_Y; direction_i = RIGHT; hold counter_i = 0; blocked = 0.
- All outputs are registered. The update occurs on the first CLK edge at which timer_done=1 and enable=1; the new values are visible from that edge. There are no multi-cycle operations.
- Per sprite per accepted tick, the two-phase sequence is PICK (counter_i==0) or HOLD (counter_i>0):
  - PICK: new dir_i = (random[3:2] + i) mod 4; counter_i <= HOLD_TICKS-1. The move on this tick uses the NEW direction.
  - HOLD: counter_i <= counter_i-1. The move uses the stored direction.
- Move legality uses unsigned arithmetic, widened 1 bit to avoid overflow:
  - UP legal if Y - SPEED >= LIMIT_UP.
  - DOWN legal if Y + SIZE + SPEED <= LIMIT_DOWN.
  - RIGHT legal if X + SIZE + SPEED <= LIMIT_RIGHT.
  - LEFT legal if X - SPEED >= LIMIT_LEFT.
  - Only the axis of the direction changes. Legal move: position updated, blocked_i <= 0. Illegal move: position held, blocked_i <= 1.
- A sprite is never driven outside the limits. A sprite that starts exactly on a limit stays there while pointed at it.
- respawn_i=1 on any cycle: sprite i goes to its start position, direction RIGHT, counter 0, blocked 0. This takes priority over a tick on the same cycle. Other sprites are unaffected.
- enable=0: ticks are dropped (not queued). respawn still acts.
- RESET asserted mid-operation: immediate return to reset values. The first accepted tick after release performs PICK for all sprites.
- timer_done held high for several cycles: each cycle counts as a tick. The driver guarantees single-cycle strobes.

Optional Feature:
BOUNCE_EN
- Defined: an illegal move reverses the direction (UP<->DOWN, LEFT<->RIGHT) and the reversed step is applied on the same tick if legal. direction_i shows the reversed value and blocked_i <= 1. The hold counter is unchanged.
- Undefined: an illegal move stalls in place as described above; direction is unchanged.

Test Plan:
- Reset, NUM_OBJ=4 -> X = 200/240/280/320, Y = 250 all, direction = RIGHT, blocked = 0.
- enable=1, random=4'b1000, one tick -> sprite0 RIGHT to X=203; sprite1 LEFT to 237; sprite2 UP to Y=247; sprite3 DOWN to Y=253. Four further ticks with random=0 -> directions kept for ticks 2-4; new pick on tick 5.
- Sprite0 forced RIGHT with X=606 (606+26+3=635) -> X=609 after one tick. Next tick refused: X stays 609, blocked=1. With BOUNCE_EN: direction=LEFT, X=606.
- Sprite2 UP with Y=87 -> refused (87-3<85), Y=87, blocked=1.
- Tick with enable=0 -> all outputs unchanged. respawn=4'b0010 coincident with a tick -> sprite1 back at (240,250) with direction RIGHT; the others move.
- RESET pulse between two ticks mid-hold -> outputs return to reset values asynchronously; the next tick performs PICK for all sprites.
